// File: rtl/rl_lj_pair_scheduler_pkg.sv
// ============================================================================
// Module   : rl_lj_pair_scheduler_pkg
// Brief    : Shared FSM encoding and default sizes for the LJ pair scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rl_lj_pair_scheduler_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t SCHED_IDLE  = 2'd0;
    localparam sched_state_t SCHED_ISSUE = 2'd1;
    localparam sched_state_t SCHED_DRAIN = 2'd2;
    localparam sched_state_t SCHED_DONE  = 2'd3;

    // The pipeline top reads the latency from here too, so it lives in one place.
    localparam int DEFAULT_REF_PARTICLE_NUM      = 100;
    localparam int DEFAULT_NEIGHBOR_PARTICLE_NUM = 100;
    localparam int DEFAULT_PIPELINE_LATENCY      = 20;

endpackage

`default_nettype wire

// File: rtl/rl_lj_pair_scheduler_pair_addr_counter.sv
// ============================================================================
// Module   : pair_addr_counter
// Brief    : Two-level nested wrap counter (reference outer, neighbor inner).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pair_addr_counter #(
    parameter int REF_NUM = 100,
    parameter int REF_W   = 7,
    parameter int NB_NUM  = 100,
    parameter int NB_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    output logic [REF_W-1:0]  ref_addr,
    output logic [NB_W-1:0]   neighbor_addr,
    output logic              ref_last,
    output logic              neighbor_last
);

    localparam logic [REF_W-1:0] c_REF_LAST = REF_W'(REF_NUM - 1);
    localparam logic [NB_W-1:0]  c_NB_LAST  = NB_W'(NB_NUM - 1);

    logic [REF_W-1:0] r_ref_addr;
    logic [NB_W-1:0]  r_nb_addr;
    logic             w_ref_last;
    logic             w_nb_last;

    assign w_ref_last = (r_ref_addr == c_REF_LAST);
    assign w_nb_last  = (r_nb_addr == c_NB_LAST);

    // The terminal pair holds so the final address stays on the RAM ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_addr <= '0;
            r_nb_addr  <= '0;
        end else if (clear) begin
            r_ref_addr <= '0;
            r_nb_addr  <= '0;
        end else if (enable && !(w_ref_last && w_nb_last)) begin
            if (w_nb_last) begin
                r_nb_addr  <= '0;
                r_ref_addr <= r_ref_addr + REF_W'(1);
            end else begin
                r_nb_addr  <= r_nb_addr + NB_W'(1);
            end
        end
    end

    assign ref_addr      = r_ref_addr;
    assign neighbor_addr = r_nb_addr;
    assign ref_last      = w_ref_last;
    assign neighbor_last = w_nb_last;

endmodule

`default_nettype wire

// File: rtl/rl_lj_pair_scheduler.sv
// ============================================================================
// Module   : rl_lj_pair_scheduler
// Brief    : Issues every (reference, neighbor) pair once, then drains latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rl_lj_pair_scheduler
    import rl_lj_pair_scheduler_pkg::*;
#(
    parameter int REF_PARTICLE_NUM        = DEFAULT_REF_PARTICLE_NUM,
    parameter int REF_RAM_ADDR_WIDTH      = 7,
    parameter int NEIGHBOR_PARTICLE_NUM   = DEFAULT_NEIGHBOR_PARTICLE_NUM,
    parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
    parameter int PIPELINE_LATENCY        = DEFAULT_PIPELINE_LATENCY,
    parameter int DRAIN_CNT_WIDTH         = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stall,
    output logic [REF_RAM_ADDR_WIDTH-1:0]      ref_addr,
    output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] neighbor_addr,
    output logic                               pair_valid,
    output logic                               last_pair,
    output logic                               busy,
    output logic                               done
);

    localparam logic [DRAIN_CNT_WIDTH-1:0] c_DRAIN_LOAD = DRAIN_CNT_WIDTH'(PIPELINE_LATENCY - 1);

    sched_state_t                r_state;
    sched_state_t                w_next_state;
    logic                        r_start_d;
    logic [DRAIN_CNT_WIDTH-1:0]  r_drain_cnt;
    logic                        w_start_edge;
    logic                        w_accept_start;
    logic                        w_ref_last;
    logic                        w_nb_last;

    assign w_start_edge   = start & ~r_start_d;
    assign w_accept_start = w_start_edge & ((r_state == SCHED_IDLE) | (r_state == SCHED_DONE));

    pair_addr_counter #(
        .REF_NUM (REF_PARTICLE_NUM),
        .REF_W   (REF_RAM_ADDR_WIDTH),
        .NB_NUM  (NEIGHBOR_PARTICLE_NUM),
        .NB_W    (NEIGHBOR_RAM_ADDR_WIDTH)
    ) u_pair_addr_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_accept_start),
        .enable        (pair_valid),
        .ref_addr      (ref_addr),
        .neighbor_addr (neighbor_addr),
        .ref_last      (w_ref_last),
        .neighbor_last (w_nb_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SCHED_IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_d <= start;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SCHED_IDLE,
            SCHED_DONE:  if (w_start_edge)        w_next_state = SCHED_ISSUE;
            SCHED_ISSUE: if (last_pair)           w_next_state = SCHED_DRAIN;
            SCHED_DRAIN: if (r_drain_cnt == '0)   w_next_state = SCHED_DONE;
            default:                              w_next_state = SCHED_IDLE;
        endcase
    end

    always_comb begin
        pair_valid = (r_state == SCHED_ISSUE) & ~stall;
        last_pair  = pair_valid & w_ref_last & w_nb_last;
        busy       = (r_state == SCHED_ISSUE) | (r_state == SCHED_DRAIN);
        done       = (r_state == SCHED_DONE);
    end

    // Loaded with latency-1 so DRAIN lasts exactly PIPELINE_LATENCY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (last_pair) begin
            r_drain_cnt <= c_DRAIN_LOAD;
        end else if ((r_state == SCHED_DRAIN) && (r_drain_cnt != '0)) begin
            r_drain_cnt <= r_drain_cnt - DRAIN_CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rl_lj_pair_scheduler.sv
// ============================================================================
// Module   : tb_rl_lj_pair_scheduler
// Brief    : Scoreboard bench for the LJ pair scheduler (3x4 pairs, latency 5).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rl_lj_pair_scheduler;

    localparam int c_REF = 3;
    localparam int c_NB  = 4;
    localparam int c_LAT = 5;
    localparam int c_BASE_DONE = c_REF * c_NB + c_LAT + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall;
    logic [6:0] ref_addr;
    logic [6:0] neighbor_addr;
    logic       pair_valid;
    logic       last_pair;
    logic       busy;
    logic       done;

    logic       start_s;
    logic       stall_s;
    logic [0:0] ref_addr_s;
    logic [0:0] neighbor_addr_s;
    logic       pair_valid_s;
    logic       last_pair_s;
    logic       busy_s;
    logic       done_s;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int r;
        int n;
        bit last;
    } pair_t;

    pair_t sb[$];

    always #5 clk = ~clk;

    rl_lj_pair_scheduler #(
        .REF_PARTICLE_NUM        (c_REF),
        .REF_RAM_ADDR_WIDTH      (7),
        .NEIGHBOR_PARTICLE_NUM   (c_NB),
        .NEIGHBOR_RAM_ADDR_WIDTH (7),
        .PIPELINE_LATENCY        (c_LAT),
        .DRAIN_CNT_WIDTH         (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .ref_addr      (ref_addr),
        .neighbor_addr (neighbor_addr),
        .pair_valid    (pair_valid),
        .last_pair     (last_pair),
        .busy          (busy),
        .done          (done)
    );

    rl_lj_pair_scheduler #(
        .REF_PARTICLE_NUM        (1),
        .REF_RAM_ADDR_WIDTH      (1),
        .NEIGHBOR_PARTICLE_NUM   (1),
        .NEIGHBOR_RAM_ADDR_WIDTH (1),
        .PIPELINE_LATENCY        (1),
        .DRAIN_CNT_WIDTH         (1)
    ) dut_small (
        .clk           (clk),
        .rst           (rst),
        .start         (start_s),
        .stall         (stall_s),
        .ref_addr      (ref_addr_s),
        .neighbor_addr (neighbor_addr_s),
        .pair_valid    (pair_valid_s),
        .last_pair     (last_pair_s),
        .busy          (busy_s),
        .done          (done_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every issued pair is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && pair_valid) begin
            if (sb.size() == 0) begin
                check("extra_pair", 1, 0);
            end else begin
                pair_t e;
                e = sb.pop_front();
                check("ref_addr", int'(ref_addr), e.r);
                check("nb_addr", int'(neighbor_addr), e.n);
                check("last_pair", int'(last_pair), int'(e.last));
            end
        end
    end

    task automatic push_pairs(input int count);
        int idx = 0;
        for (int r = 0; r < c_REF; r++) begin
            for (int n = 0; n < c_NB; n++) begin
                pair_t p;
                p.r = r;
                p.n = n;
                p.last = (r == c_REF - 1) && (n == c_NB - 1);
                if (idx < count) sb.push_back(p);
                idx++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // stall_mode 1: 3 stalls on pair (1,2), 1 stall on (2,3).
    // poke_mode 1: extra start pulses in ISSUE and DRAIN; 2: start held high.
    task automatic run_case(input string tag, input int stall_mode, input int poke_mode,
                            input int exp_done);
        int first_done = -1;
        int busy_cnt = 0;
        push_pairs(c_REF * c_NB);
        start = 1'b0;
        step();
        start = 1'b1;
        for (int k = 1; k <= exp_done + 10 && first_done < 0; k++) begin
            step();
            stall = (stall_mode == 1) && ((k >= 7 && k <= 9) || k == 15);
            if (poke_mode == 0)      start = 1'b0;
            else if (poke_mode == 1) start = (k == 5) || (k == 15);
            else                     start = 1'b1;
            #1;
            if (stall_mode == 1 && k == 15) check({tag, "_last_stalled"}, int'(last_pair), 0);
            if (done) first_done = k;
            else if (busy) busy_cnt++;
        end
        stall = 1'b0;
        check({tag, "_done_cycle"}, first_done, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int first_done;
        int pv_cnt;
        int lp_cnt;

        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        start_s = 1'b0;
        stall_s = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_pair_valid", int'(pair_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(ref_addr) + int'(neighbor_addr), 0);

        run_case("basic", 0, 0, c_BASE_DONE);
        run_case("stall", 1, 0, c_BASE_DONE + 4);
        run_case("poke", 0, 1, c_BASE_DONE);

        // Start held high across completion must not retrigger.
        run_case("held", 0, 2, c_BASE_DONE);
        repeat (8) step();
        check("held_done", int'(done), 1);
        check("held_busy", int'(busy), 0);
        run_case("restart", 0, 0, c_BASE_DONE);

        // Async reset in the middle of pair (1,1).
        push_pairs(5);
        start = 1'b0;
        step();
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            start = 1'b0;
        end
        #1;
        check("pre_rst_ref", int'(ref_addr), 1);
        check("pre_rst_nb", int'(neighbor_addr), 1);
        rst = 1'b1;
        #1;
        check("async_pair_valid", int'(pair_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_addr", int'(ref_addr) + int'(neighbor_addr), 0);
        step();
        rst = 1'b0;
        repeat (5) step();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();

        // Single pair, latency 1.
        first_done = -1;
        pv_cnt = 0;
        lp_cnt = 0;
        start_s = 1'b1;
        for (int k = 1; k <= 10 && first_done < 0; k++) begin
            step();
            start_s = 1'b0;
            if (pair_valid_s) pv_cnt++;
            if (pair_valid_s && last_pair_s) lp_cnt++;
            if (done_s) first_done = k;
        end
        check("small_pairs", pv_cnt, 1);
        check("small_last", lp_cnt, 1);
        check("small_done_cycle", first_done, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
